// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit and the CPU top.
// Holds the FSM state encoding, op codes, iteration count and Div0 vector.
package mdu_pkg;

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} mdu_state_t;

  localparam logic        MDU_MULT        = 1'b0;
  localparam logic        MDU_DIV         = 1'b1;
  localparam int          MDU_ITER        = 32;
  localparam logic [31:0] MDU_DIV0_VECTOR = 32'h000000FF;

  // |x| as 32-bit unsigned; -2^31 maps to 0x80000000, which is what the divider wants.
  function automatic logic [31:0] absVal(input logic [31:0] x);
    return x[31] ? -x : x;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Request/response bundle between the CPU control unit and the multiply/divide unit.
// master = control unit (issues start/op/a/b), slave = multiply/divide unit.
interface mult_div_unit_if;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, done, div_zero, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/booth_step.sv
// One radix-2 Booth step: add/subtract the multiplicand on a 33-bit upper path,
// then arithmetic shift right; the redundant sign copy is dropped to keep 65 bits.
module booth_step (
  input  logic [64:0] acc,
  input  logic [31:0] mcand,
  output logic [64:0] nextAcc
);

  logic [32:0] upper;
  logic [32:0] addend;
  logic [32:0] sum;

  always_comb begin
    upper  = {acc[64], acc[64:33]};
    addend = {mcand[31], mcand};
    case (acc[1:0])
      2'b01:   sum = upper + addend;
      2'b10:   sum = upper - addend;
      default: sum = upper;
    endcase
    nextAcc = {sum, acc[32:1]};
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed MIPS mult/div: 33 cycles to done for mult, 34 for div, 1 for div-by-zero.
// start is only accepted in IDLE; requests while busy are dropped, there is no queue.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int ITER = MDU_ITER
) (
  input  logic           clock,
  input  logic           reset,
  mult_div_unit_if.slave bus
);

  mdu_state_t  state, nextState;
  logic [5:0]  cnt;
  logic [64:0] acc, boothNext;
  logic [31:0] mcand, rem, dvd, divisor, hiReg, loReg;
  logic        aNeg, qNeg, dzFlag, doneReg, divZeroReg;
  logic        lastStep;
  logic [32:0] shifted;
  logic [33:0] diff;
  logic [31:0] remNext;
  logic        quoBit;

  booth_step uBooth (
    .acc     (acc),
    .mcand   (mcand),
    .nextAcc (boothNext)
  );

  assign lastStep = (cnt == 6'(ITER - 1));

  // Restoring step: dvd shifts out dividend bits on top and collects quotient bits below.
  always_comb begin
    shifted = {rem, dvd[31]};
    diff    = {1'b0, shifted} - {2'b00, divisor};
    quoBit  = ~diff[33];
    remNext = diff[33] ? 32'(shifted) : 32'(diff);
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.op == MDU_MULT) nextState = MULT;
          else if (bus.b == '0)   nextState = DONE;
          else                    nextState = DIV;
        end
      end
      MULT:    if (lastStep) nextState = DONE;
      DIV:     if (lastStep) nextState = FIX;
      FIX:     nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      acc        <= '0;
      mcand      <= '0;
      rem        <= '0;
      dvd        <= '0;
      divisor    <= '0;
      aNeg       <= 1'b0;
      qNeg       <= 1'b0;
      dzFlag     <= 1'b0;
      hiReg      <= '0;
      loReg      <= '0;
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
    end else begin
      doneReg    <= 1'b0;
      divZeroReg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt    <= '0;
            dzFlag <= 1'b0;
            if (bus.op == MDU_MULT) begin
              acc   <= {32'b0, bus.b, 1'b0};
              mcand <= bus.a;
            end else if (bus.b == '0) begin
              dzFlag <= 1'b1;
            end else begin
              dvd     <= absVal(bus.a);
              divisor <= absVal(bus.b);
              aNeg    <= bus.a[31];
              qNeg    <= bus.a[31] ^ bus.b[31];
              rem     <= '0;
            end
          end
        end
        MULT: begin
          acc <= boothNext;
          cnt <= cnt + 6'd1;
          if (lastStep) begin
            hiReg <= boothNext[64:33];
            loReg <= boothNext[32:1];
          end
        end
        DIV: begin
          rem <= remNext;
          dvd <= {dvd[30:0], quoBit};
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          loReg <= qNeg ? -dvd : dvd;
          hiReg <= aNeg ? -rem : rem;
        end
        DONE: begin
          doneReg    <= ~dzFlag;
          divZeroReg <= dzFlag;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state != IDLE);
  assign bus.done     = doneReg;
  assign bus.div_zero = divZeroReg;
  assign bus.hi       = hiReg;
  assign bus.lo       = loReg;

endmodule
